// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_pkg
//  Brief    : Shared constants and width helper for the debounce bank.
//  Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    localparam int EDGE_FALL = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_BOTH = 2;

    // Width needed to hold the values 0..long_cyc inclusive.
    function automatic int hold_width(input int long_cyc);
        return (long_cyc < 1) ? 1 : $clog2(long_cyc + 1);
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_chan
//  Brief    : One debounce channel: synchroniser, stability filter, edge and
//             long-press pulses, sticky event flag.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   CNT_W     = 16,
    parameter int   LONG_CYC  = 1000000,
    parameter int   EDGE_MODE = 0,
    parameter logic RST_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_i,
    input  logic [CNT_W-1:0] thr_i,
    input  logic             evt_clr_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             long_o,
    output logic             evt_o
);

    localparam int                  c_hold_w   = hold_width(LONG_CYC);
    localparam logic [c_hold_w-1:0] c_long_max = c_hold_w'(LONG_CYC);
    localparam logic [c_hold_w-1:0] c_long_m1  = c_hold_w'(LONG_CYC - 1);

    logic                r_s1, r_s2, r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_hold_w-1:0] r_hold;
    logic                r_rise, r_fall, r_long, r_evt;

    logic [CNT_W-1:0]    w_thr_eff;
    logic                w_match, w_flip;
    logic                w_rise_nxt, w_fall_nxt, w_long_nxt, w_sel;

    always_comb begin
        w_thr_eff  = (thr_i == '0) ? CNT_W'(1) : thr_i;
        w_match    = (r_s2 == r_state);
        // >= so that lowering the threshold below a running count flips at once
        w_flip     = !w_match && (r_cnt >= (w_thr_eff - CNT_W'(1)));
        w_rise_nxt = w_flip && r_s2;
        w_fall_nxt = w_flip && !r_s2;
        w_long_nxt = r_state && (r_hold == c_long_m1) && !w_fall_nxt;
        case (EDGE_MODE)
            EDGE_FALL: w_sel = w_fall_nxt;
            EDGE_RISE: w_sel = w_rise_nxt;
            default:   w_sel = w_rise_nxt | w_fall_nxt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= RST_LEVEL;
            r_s2    <= RST_LEVEL;
            r_state <= RST_LEVEL;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_long  <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_s1 <= in_i;
            r_s2 <= r_s1;
            if (w_match) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_state <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Saturating hold means long_o can only fire once per high period
            if (!r_state)
                r_hold <= '0;
            else if (r_hold != c_long_max)
                r_hold <= r_hold + c_hold_w'(1);
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            r_long <= w_long_nxt;
            r_evt  <= w_sel | (r_evt & ~evt_clr_i);
        end
    end

    assign level_o = r_state;
    assign rise_o  = r_rise;
    assign fall_o  = r_fall;
    assign long_o  = r_long;
    assign evt_o   = r_evt;

endmodule : debounce_chan
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_bank
//  Brief    : NCH independent debounce channels sharing clock, reset and
//             stability threshold.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int   NCH       = 4,
    parameter int   CNT_W     = 16,
    parameter int   LONG_CYC  = 1000000,
    parameter int   EDGE_MODE = 0,
    parameter logic RST_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   in_i,
    input  logic [CNT_W-1:0] thr_i,
    input  logic [NCH-1:0]   evt_clr_i,
    output logic [NCH-1:0]   level_o,
    output logic [NCH-1:0]   rise_o,
    output logic [NCH-1:0]   fall_o,
    output logic [NCH-1:0]   long_o,
    output logic [NCH-1:0]   evt_o
);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        debounce_chan #(
            .CNT_W     (CNT_W),
            .LONG_CYC  (LONG_CYC),
            .EDGE_MODE (EDGE_MODE),
            .RST_LEVEL (RST_LEVEL)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_i      (in_i[c]),
            .thr_i     (thr_i),
            .evt_clr_i (evt_clr_i[c]),
            .level_o   (level_o[c]),
            .rise_o    (rise_o[c]),
            .fall_o    (fall_o[c]),
            .long_o    (long_o[c]),
            .evt_o     (evt_o[c])
        );
    end

endmodule : debounce_bank
`default_nettype wire
